sar_conv_ctrl: RTL
==================

# sar_conv_ctrl

Successive-approximation controller that drives the 12-bit trial code into the peripheral magnitude comparer and consumes its 1-bit decision. It turns the comparer into a 12-bit digitiser for the morphing-wing sensor channels. The comparer connections are fixed:

- comparer `in0` = `trial_code`
- comparer `in1` = sampled sensor value
- comparer `out` → `cmp_le` (1 when `in0 <= in1`)

The block sits between the sensor front-end/comparer and the peripheral register block, which reads `result`.

## Interface
Parameters:
- `WIDTH`, 12, code width; must match comparer input width.
- `SETTLE_CYCLES`, 2, extra cycles each trial code is held before `cmp_le` is sampled (0..15).

Ports:
- `clk`, input, 1, sole clock; all logic rising-edge.
- `rst`, input, 1, synchronous, active-high reset.
- `start`, input, 1, conversion request; sampled only in IDLE.
- `cmp_le`, input, 1, comparer output; 1 means trial_code <= sample, so the trial bit is kept.
- `trial_code`, output, WIDTH, code driven to comparer `in0`.
- `busy`, output, 1, high from the cycle after start is accepted until the DONE cycle, inclusive.
- `done`, output, 1, one-cycle pulse when `result` is updated.
- `result`, output, WIDTH, last completed conversion; held until the next `done`.
- `abort`, input, 1, present only with `SAR_ABORT_EN` (see Configuration).

## Operation
- **States:** IDLE, TRIAL, DONE.
- **IDLE:**
  - `start=1` → TRIAL.
  - `bit_idx=WIDTH-1`.
  - `trial_code` becomes `1<<(WIDTH-1)` (0x800) on the entry edge.
- **TRIAL:**
  - Hold `trial_code` for `SETTLE_CYCLES+1` cycles, timed by a settle counter.
  - On the last cycle, sample `cmp_le`.
  - `cmp_le=1` → keep bit `bit_idx`; `cmp_le=0` → clear it.
  - If `bit_idx>0`, set bit `bit_idx-1` and decrement `bit_idx`.
  - If `bit_idx==0` → DONE.
  - Bits below the current trial bit are always 0.
- **DONE** (exactly one cycle):
  - `result <= trial_code` (final code).
  - `done=1`, `busy=1`.
  - Next state IDLE.
  - `trial_code` holds the final code until the next start.
- **Start while busy:** `start` during TRIAL or DONE is ignored, not queued.
- **Start in the IDLE cycle after DONE:** accepted normally, giving back-to-back conversions.
- **Arithmetic:** plain unsigned compare semantics; no sign handling.
  - sample 0 → result 0.
  - sample `2^WIDTH-1` → result all ones.
- **Reset mid-conversion:**
  - Next edge → IDLE.
  - `trial_code=0`, `result=0`, `busy=0`, `done=0`.
  - No `done` pulse; the partial code is discarded.
- **Reset values:** all outputs 0; settle counter 0; `bit_idx=WIDTH-1`.

## Timing
- Start accepted at edge k (state IDLE, `start=1`).
- `busy` and `trial_code=0x800` are visible after edge k.
- Each bit occupies `SETTLE_CYCLES+1` cycles.
- `done` and the new `result` are visible after edge k+WIDTH*(SETTLE_CYCLES+1)+1.
  - Default: k+37.
- `busy` falls one cycle after `done`.
- `cmp_le` is treated as combinational from `trial_code`; no synchroniser, since the comparer shares `clk`'s domain via a static sample.

## Configuration
- `SAR_ABORT_EN`:
  - **Defined:**
    - Adds the `abort` input.
    - `abort=1` in TRIAL → next edge IDLE, `busy=0`, `trial_code=0`.
    - `result` is unchanged and no `done` is issued.
    - `abort` in IDLE or DONE has no effect (DONE completes).
    - `abort` and `rst` together → `rst` wins (same visible outcome).
  - **Undefined:** no `abort` port; conversions always run to completion.

## Structure
- Package `sar_pkg`:
  - state enum `sar_state_t` (IDLE, TRIAL, DONE).
  - `SAR_WIDTH_DEF=12`, `SAR_SETTLE_DEF=2`.
  - function `sar_latency(width, settle)` returning `width*(settle+1)+1`, shared with the bench.
- Sub-module `sar_settle_timer`:
  - load/count-down counter with a `tc` (terminal count) output.
  - Asserts `tc` on the last hold cycle of each trial.
  - Reset to 0 on `rst`.

## Test plan
All scenarios use a bench-modelled comparer: `cmp_le = (trial_code <= sample)`.

- sample=0xA5C, start at cycle 0 → `trial_code` sequence 0x800, 0xC00 (then cleared to 0x800), 0xA00, …; `done` one cycle at cycle 37; `result=0xA5C`; `busy` low at 38.
- sample=0x000, then sample=0xFFF, back-to-back starts → results 0x000 then 0xFFF; second `done` exactly 38 cycles after the first.
- `start` held high through a conversion (sample=0x123) → exactly one `done` per accepted start, at cycle 37 and then 75; `result=0x123`.
- `rst` asserted at cycle 10 of a conversion (sample=0x7FF, prior `result=0x456`) → all outputs 0 after the edge, no `done`; a new start yields 0x7FF at +37.
- `SETTLE_CYCLES=0`, sample=0x001 → `done` at cycle 13, `result=0x001`.
- `SAR_ABORT_EN` defined: prior `result=0x3C3`, abort at cycle 20 → IDLE next edge, no `done`, `result` stays 0x3C3.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation conversion controller.
// Holds the FSM encoding, default geometry and the start-to-done latency helper.
package sar_pkg;

  localparam int SAR_WIDTH_DEF  = 12;
  localparam int SAR_SETTLE_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIAL = 2'd1,
    DONE  = 2'd2
  } sar_state_t;

  // Edges from start acceptance to the edge that makes done/result visible.
  function automatic int sar_latency(input int width, input int settle);
    return width * (settle + 1) + 1;
  endfunction

endpackage

// File: rtl/sar_settle_timer.sv
// Settle timer: loadable down-counter, tc high while the count is zero (last hold cycle).
// Latency: load visible next cycle. No backpressure; load has priority over dec.
module sar_settle_timer
  import sar_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/sar_conv_ctrl.sv
// SAR controller: drives trial_code into the comparer, resolves one bit per SETTLE_CYCLES+1 cycles.
// Latency: done/result sar_latency(WIDTH,SETTLE_CYCLES) edges after start; start ignored while busy.
// Optional SAR_ABORT_EN adds an abort input that cancels a conversion in TRIAL.
module sar_conv_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH_DEF,
  parameter int SETTLE_CYCLES = SAR_SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_le,
`ifdef SAR_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] trial_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int             IW        = $clog2(WIDTH);
  localparam logic [IW-1:0]  MSB_IDX   = IW'(WIDTH - 1);
  localparam logic [3:0]     SETTLE_LD = 4'(SETTLE_CYCLES);

  sar_state_t       state, state_nxt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] cur_bit, code_step;
  logic             tc, abort_req;
  logic             accept, kill, step, busy_nxt, done_nxt;

`ifdef SAR_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = TRIAL;
      TRIAL: begin
        if (abort_req)                   state_nxt = IDLE;
        else if (tc && bit_idx == '0)    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done and busy are registered, so they trail the state by one edge; busy covers that extra cycle.
  always_comb begin
    accept   = (state == IDLE) && start;
    kill     = (state == TRIAL) && abort_req;
    step     = (state == TRIAL) && tc && !abort_req;
    done_nxt = (state == DONE);
    busy_nxt = (state_nxt != IDLE) || (state == DONE);
  end

  // Resolve the current bit and arm the next lower one; at bit 0 the shift leaves nothing to arm.
  always_comb begin
    cur_bit   = WIDTH'(1) << bit_idx;
    code_step = cmp_le ? trial_code : (trial_code & ~cur_bit);
    code_step = code_step | (cur_bit >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trial_code <= '0;
      result     <= '0;
      bit_idx    <= MSB_IDX;
    end else begin
      if (accept) begin
        trial_code <= WIDTH'(1) << MSB_IDX;
        bit_idx    <= MSB_IDX;
      end else if (kill) begin
        trial_code <= '0;
        bit_idx    <= MSB_IDX;
      end else if (step) begin
        trial_code <= code_step;
        if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
      end else if (state == DONE) begin
        bit_idx <= MSB_IDX;
      end
      if (state == DONE) result <= trial_code;
    end
  end

  sar_settle_timer #(.CW(4)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (accept || step),
    .load_val (SETTLE_LD),
    .dec      (state == TRIAL),
    .tc       (tc)
  );

endmodule
